// File: rtl/ps2_command_tx.sv
// ps2_command_tx: host-to-device PS/2 command transmitter.
// Sends one command byte (start, d0..d7, odd parity, stop) over open-drain
// PS/2 clock/data lines and checks the device acknowledge bit.
module ps2_command_tx #(
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       send_command,
  input  logic [7:0] command,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_timeout,
  output logic       error_no_ack
);

  // Reject parameter sets the counters cannot represent.
  if (CLK_FREQ_HZ <= 0 || INHIBIT_CYCLES < 1 || START_TIMEOUT < 1 || XFER_TIMEOUT < 1) begin : g_bad_params
    $error("ps2_command_tx: invalid parameter set");
  end

  localparam int INH_CNT_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int ST_CNT_W  = $clog2(START_TIMEOUT + 1);
  localparam int XF_CNT_W  = $clog2(XFER_TIMEOUT + 1);

  localparam logic [INH_CNT_W-1:0] INH_LAST = INH_CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_CNT_W-1:0] INH_MAX  = INH_CNT_W'(INHIBIT_CYCLES);
  localparam logic [ST_CNT_W-1:0]  ST_LAST  = ST_CNT_W'(START_TIMEOUT - 1);
  localparam logic [ST_CNT_W-1:0]  ST_MAX   = ST_CNT_W'(START_TIMEOUT);
  localparam logic [XF_CNT_W-1:0]  XF_LAST  = XF_CNT_W'(XFER_TIMEOUT - 1);
  localparam logic [XF_CNT_W-1:0]  XF_MAX   = XF_CNT_W'(XFER_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_INHIBIT      = 3'd1,
    ST_START        = 3'd2,
    ST_WAIT_FIRST   = 3'd3,
    ST_XFER         = 3'd4,
    ST_WAIT_RELEASE = 3'd5
  } state_t;

  // Odd parity bit for a command byte: 1 when the byte has an even number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  state_t               state_r, state_s;
  logic [7:0]           cmd_r, cmd_s;
  logic [3:0]           edge_cnt_r, edge_cnt_s;
  logic [INH_CNT_W-1:0] inh_cnt_r, inh_cnt_s;
  logic [ST_CNT_W-1:0]  st_cnt_r, st_cnt_s;
  logic [XF_CNT_W-1:0]  xf_cnt_r, xf_cnt_s;
  logic                 dat_low_r, dat_low_s;
  logic                 clk_low_r;
  logic                 busy_r;
  logic                 sent_r, sent_s;
  logic                 tout_r, tout_s;
  logic                 noack_r, noack_s;

  logic clk_meta_r, clk_sync_r, clk_prev_r;
  logic dat_meta_r, dat_sync_r;
  logic clk_fall_s;

  // Two-flop synchronizers for both raw lines plus the clock history flop; idle bus is high.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      clk_prev_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= ps2_clk_i;
      clk_sync_r <= clk_meta_r;
      clk_prev_r <= clk_sync_r;
      dat_meta_r <= ps2_dat_i;
      dat_sync_r <= dat_meta_r;
    end
  end

  assign clk_fall_s = clk_prev_r & ~clk_sync_r;

  // Next-state, counter, data-line and result-pulse logic.
  always_comb begin
    state_s    = state_r;
    cmd_s      = cmd_r;
    edge_cnt_s = edge_cnt_r;
    inh_cnt_s  = inh_cnt_r;
    st_cnt_s   = st_cnt_r;
    xf_cnt_s   = xf_cnt_r;
    dat_low_s  = dat_low_r;
    sent_s     = 1'b0;
    tout_s     = 1'b0;
    noack_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        dat_low_s = 1'b0;
        if (send_command) begin
          state_s    = ST_INHIBIT;
          cmd_s      = command;
          edge_cnt_s = 4'd0;
          inh_cnt_s  = '0;
          st_cnt_s   = '0;
          xf_cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_INHIBIT: begin
        if (inh_cnt_r == INH_LAST) begin
          state_s   = ST_START;
          dat_low_s = 1'b1;
        end else begin
          dat_low_s = 1'b0;
          inh_cnt_s = (inh_cnt_r == INH_MAX) ? inh_cnt_r : inh_cnt_r + INH_CNT_W'(1);
        end
      end

      ST_START: begin
        // Start bit stays driven while the clock is released.
        dat_low_s = 1'b1;
        st_cnt_s  = '0;
        state_s   = ST_WAIT_FIRST;
      end

      ST_WAIT_FIRST: begin
        if (clk_fall_s) begin
          state_s    = ST_XFER;
          edge_cnt_s = 4'd1;
          dat_low_s  = ~cmd_r[0];
          xf_cnt_s   = '0;
        end else if (st_cnt_r == ST_LAST) begin
          state_s   = ST_IDLE;
          dat_low_s = 1'b0;
          tout_s    = 1'b1;
        end else begin
          st_cnt_s = (st_cnt_r == ST_MAX) ? st_cnt_r : st_cnt_r + ST_CNT_W'(1);
        end
      end

      ST_XFER: begin
        xf_cnt_s = (xf_cnt_r == XF_MAX) ? xf_cnt_r : xf_cnt_r + XF_CNT_W'(1);
        if (xf_cnt_r == XF_LAST) begin
          state_s   = ST_IDLE;
          dat_low_s = 1'b0;
          tout_s    = 1'b1;
        end else if (clk_fall_s) begin
          // edge_cnt_r holds the number of edges already handled.
          edge_cnt_s = edge_cnt_r + 4'd1;
          case (edge_cnt_r)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
              dat_low_s = ~cmd_r[edge_cnt_r[2:0]];
            end
            4'd8: begin
              dat_low_s = ~odd_parity(cmd_r);
            end
            4'd9: begin
              dat_low_s = 1'b0;
            end
            4'd10: begin
              dat_low_s = 1'b0;
              if (!dat_sync_r) begin
                state_s = ST_WAIT_RELEASE;
              end else begin
                state_s = ST_IDLE;
                noack_s = 1'b1;
              end
            end
            default: begin
              dat_low_s = 1'b0;
            end
          endcase
        end else begin
          state_s = ST_XFER;
        end
      end

      ST_WAIT_RELEASE: begin
        dat_low_s = 1'b0;
        xf_cnt_s  = (xf_cnt_r == XF_MAX) ? xf_cnt_r : xf_cnt_r + XF_CNT_W'(1);
        if (clk_sync_r && dat_sync_r) begin
          state_s = ST_IDLE;
          sent_s  = 1'b1;
        end else if (xf_cnt_r == XF_LAST) begin
          state_s = ST_IDLE;
          tout_s  = 1'b1;
        end else begin
          state_s = ST_WAIT_RELEASE;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        dat_low_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered line/status outputs derived from the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      cmd_r      <= 8'h00;
      edge_cnt_r <= 4'd0;
      inh_cnt_r  <= '0;
      st_cnt_r   <= '0;
      xf_cnt_r   <= '0;
      dat_low_r  <= 1'b0;
      clk_low_r  <= 1'b0;
      busy_r     <= 1'b0;
      sent_r     <= 1'b0;
      tout_r     <= 1'b0;
      noack_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cmd_r      <= cmd_s;
      edge_cnt_r <= edge_cnt_s;
      inh_cnt_r  <= inh_cnt_s;
      st_cnt_r   <= st_cnt_s;
      xf_cnt_r   <= xf_cnt_s;
      dat_low_r  <= dat_low_s;
      clk_low_r  <= (state_s == ST_INHIBIT) || (state_s == ST_START);
      busy_r     <= (state_s != ST_IDLE);
      sent_r     <= sent_s;
      tout_r     <= tout_s;
      noack_r    <= noack_s;
    end
  end

  assign ps2_clk_drive_low = clk_low_r;
  assign ps2_dat_drive_low = dat_low_r;
  assign busy              = busy_r;
  assign command_was_sent  = sent_r;
  assign error_timeout     = tout_r;
  assign error_no_ack      = noack_r;

endmodule
